// File: rtl/led_frame_buffer_pkg.sv
// Shared types and defaults for the double-buffered LED frame store.
// FSM encoding, default geometry and the frame counter width live here.
package led_fb_pkg;

  localparam int ROWS_DEF        = 16;
  localparam int COLS_DEF        = 16;
  localparam int BLINK_TICKS_DEF = 8;
  localparam int FCNT_W          = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    SWAP    = 2'd2
  } fb_state_e;

endpackage

// File: rtl/led_frame_buffer_if.sv
// Row-write port: valid/ready handshake carrying a row index and both colour planes.
// The producer is the master; the frame buffer is the slave and drives ready.
interface led_frame_buffer_if #(
  parameter int ROWS = 16,
  parameter int COLS = 16
) ();

  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

  logic            wr_valid;
  logic            wr_ready;
  logic [RW-1:0]   wr_row;
  logic [COLS-1:0] wr_red;
  logic [COLS-1:0] wr_green;

  modport master (output wr_valid, wr_row, wr_red, wr_green, input wr_ready);
  modport slave  (input wr_valid, wr_row, wr_red, wr_green, output wr_ready);

endinterface

// File: rtl/led_frame_buffer_blinker.sv
// Blink phase generator: counts frame ticks and toggles blank every BLINK_TICKS ticks.
// Only present when LED_FRAME_BUFFER_BLINK_EN is defined; blank is a plain register.
`ifdef LED_FRAME_BUFFER_BLINK_EN
module led_fb_blinker
  import led_fb_pkg::*;
#(
  parameter int BLINK_TICKS = BLINK_TICKS_DEF
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic tick,
  output logic blank
);

  localparam int CW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt   <= '0;
      blank <= 1'b0;
    end else if (tick) begin
      if (cnt == CW'(BLINK_TICKS - 1)) begin
        cnt   <= '0;
        blank <= ~blank;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule
`endif

// File: rtl/led_frame_buffer.sv
// Double-buffered LED frame store: rows land in a back buffer, swap to front on the tick after a commit.
// Writes stall (wr_ready=0) from commit until the swap completes; blanking via LED_FRAME_BUFFER_BLINK_EN.
module led_frame_buffer
  import led_fb_pkg::*;
#(
  parameter int ROWS        = ROWS_DEF,
  parameter int COLS        = COLS_DEF,
  parameter int BLINK_TICKS = BLINK_TICKS_DEF
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  led_frame_buffer_if.slave          wr,
  input  logic                       clear,
  input  logic                       commit,
  input  logic                       tick,
  input  logic                       blink_en,
  output logic                       swap_pending,
  output logic [FCNT_W-1:0]          frame_cnt,
  output logic [ROWS-1:0][COLS-1:0]  red,
  output logic [ROWS-1:0][COLS-1:0]  green
);

  fb_state_e                 state;
  logic [ROWS-1:0][COLS-1:0] back_r, back_g;
  logic [ROWS-1:0][COLS-1:0] front_r, front_g;
  logic [ROWS-1:0][COLS-1:0] shown_r, shown_g;
  logic                      row_ok;
  logic                      wr_fire;

  assign wr.wr_ready  = (state == IDLE);
  assign swap_pending = (state == PENDING);
  assign wr_fire      = wr.wr_valid && wr.wr_ready;
  assign row_ok       = (int'(wr.wr_row) < ROWS);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= IDLE;
      back_r    <= '0;
      back_g    <= '0;
      front_r   <= '0;
      front_g   <= '0;
      frame_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (clear) begin
            back_r <= '0;
            back_g <= '0;
          end
          // Later assignment wins, so a write colliding with clear keeps its row.
          if (wr_fire && row_ok) begin
            back_r[wr.wr_row] <= wr.wr_red;
            back_g[wr.wr_row] <= wr.wr_green;
          end
          if (commit) state <= PENDING;
        end
        PENDING: begin
          if (tick) state <= SWAP;
        end
        SWAP: begin
          front_r   <= back_r;
          front_g   <= back_g;
          frame_cnt <= frame_cnt + 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef LED_FRAME_BUFFER_BLINK_EN
  logic blank;

  led_fb_blinker #(
    .BLINK_TICKS (BLINK_TICKS)
  ) u_blinker (
    .CLK   (CLK),
    .RST_N (RST_N),
    .tick  (tick),
    .blank (blank)
  );

  // Display register tracks what front will hold after this edge, masked by the blink phase.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      shown_r <= '0;
      shown_g <= '0;
    end else if (blank && blink_en) begin
      shown_r <= '0;
      shown_g <= '0;
    end else if (state == SWAP) begin
      shown_r <= back_r;
      shown_g <= back_g;
    end else begin
      shown_r <= front_r;
      shown_g <= front_g;
    end
  end
`else
  logic unused_cfg;

  assign unused_cfg = blink_en | (BLINK_TICKS < 1);
  assign shown_r    = front_r;
  assign shown_g    = front_g;
`endif

  // Logical row i is driven onto physical row ROWS-1-i.
  for (genvar i = 0; i < ROWS; i++) begin : g_flip
    assign red[ROWS-1-i]   = shown_r[i];
    assign green[ROWS-1-i] = shown_g[i];
  end

endmodule

// File: tb/tb_led_frame_buffer.sv
// Randomised and directed bench for led_frame_buffer against a frame-level reference model.
module tb_led_frame_buffer;
  import led_fb_pkg::*;

  localparam int R  = 12;
  localparam int C  = 16;
  localparam int BT = 2;

  logic                 CLK = 1'b0;
  logic                 RST_N = 1'b0;
  logic                 clear = 1'b0;
  logic                 commit = 1'b0;
  logic                 tick = 1'b0;
  logic                 blink_en = 1'b0;
  logic                 swap_pending;
  logic [FCNT_W-1:0]    frame_cnt;
  logic [R-1:0][C-1:0]  red, green;

  int errors = 0;
  int checks = 0;

  led_frame_buffer_if #(.ROWS(R), .COLS(C)) wif ();

  led_frame_buffer #(.ROWS(R), .COLS(C), .BLINK_TICKS(BT)) dut (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .wr           (wif),
    .clear        (clear),
    .commit       (commit),
    .tick         (tick),
    .blink_en     (blink_en),
    .swap_pending (swap_pending),
    .frame_cnt    (frame_cnt),
    .red          (red),
    .green        (green)
  );

  always #5 CLK = ~CLK;

  // Reference model: frame-level view of the buffers and the commit/tick protocol.
  logic [C-1:0] m_back_r[R], m_back_g[R], m_front_r[R], m_front_g[R];
  logic [C-1:0] m_disp_r[R], m_disp_g[R];
  bit           m_pending, m_swap, m_blank;
  int           m_tcnt;
  logic [7:0]   m_cnt;

  task automatic model_reset();
    for (int i = 0; i < R; i++) begin
      m_back_r[i] = '0; m_back_g[i] = '0; m_front_r[i] = '0; m_front_g[i] = '0;
      m_disp_r[i] = '0; m_disp_g[i] = '0;
    end
    m_pending = 0; m_swap = 0; m_blank = 0; m_tcnt = 0; m_cnt = '0;
  endtask

  task automatic model_edge();
    bit old_blank;
    old_blank = m_blank;
    if (m_swap) begin
      for (int i = 0; i < R; i++) begin
        m_front_r[i] = m_back_r[i];
        m_front_g[i] = m_back_g[i];
      end
      m_cnt  = m_cnt + 8'd1;
      m_swap = 0;
    end else if (m_pending) begin
      if (tick) begin
        m_pending = 0;
        m_swap    = 1;
      end
    end else begin
      if (clear)
        for (int i = 0; i < R; i++) begin
          m_back_r[i] = '0; m_back_g[i] = '0;
        end
      if (wif.wr_valid && int'(wif.wr_row) < R) begin
        m_back_r[wif.wr_row] = wif.wr_red;
        m_back_g[wif.wr_row] = wif.wr_green;
      end
      if (commit) m_pending = 1;
    end
`ifdef LED_FRAME_BUFFER_BLINK_EN
    if (tick) begin
      if (m_tcnt == BT - 1) begin
        m_tcnt  = 0;
        m_blank = !m_blank;
      end else begin
        m_tcnt = m_tcnt + 1;
      end
    end
`endif
    for (int i = 0; i < R; i++) begin
      m_disp_r[i] = (old_blank && blink_en) ? '0 : m_front_r[i];
      m_disp_g[i] = (old_blank && blink_en) ? '0 : m_front_g[i];
    end
  endtask

  function automatic logic [R-1:0][C-1:0] exp_red();
    exp_red = '0;
    for (int i = 0; i < R; i++) exp_red[R-1-i] = m_disp_r[i];
  endfunction

  function automatic logic [R-1:0][C-1:0] exp_green();
    exp_green = '0;
    for (int i = 0; i < R; i++) exp_green[R-1-i] = m_disp_g[i];
  endfunction

  // Advance one clock: model follows the edge, outputs are sampled on the following falling edge.
  task automatic step();
    @(posedge CLK);
    model_edge();
    @(negedge CLK);
  endtask

  task automatic idle_inputs();
    wif.wr_valid = 1'b0; wif.wr_row = '0; wif.wr_red = '0; wif.wr_green = '0;
    clear = 1'b0; commit = 1'b0; tick = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    @(negedge CLK);
    RST_N = 1'b0;
    model_reset();
    @(negedge CLK);
    RST_N = 1'b1;
  endtask

  task automatic write_row(input logic [3:0] row, input logic [C-1:0] r, input logic [C-1:0] g);
    wif.wr_valid = 1'b1; wif.wr_row = row; wif.wr_red = r; wif.wr_green = g;
    step();
    wif.wr_valid = 1'b0;
  endtask

  task automatic commit_and_tick();
    commit = 1'b1; step(); commit = 1'b0;
    tick = 1'b1; step(); tick = 1'b0;
    step();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (wif.wr_ready !== 1'b1 || swap_pending !== 1'b0 || frame_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_ctrl: got rdy=%b pend=%b cnt=%0d want rdy=1 pend=0 cnt=0",
               wif.wr_ready, swap_pending, frame_cnt);
    end
    checks++;
    if (red !== '0 || green !== '0) begin
      errors++;
      $display("FAIL reset_pix: got red=%h green=%h want 0", red, green);
    end
    write_row(4'd3, 16'h00FF, 16'h0000);
    commit = 1'b1; step(); commit = 1'b0;
    checks++;
    if (swap_pending !== 1'b1) begin
      errors++;
      $display("FAIL commit_pending: got %b want 1", swap_pending);
    end
    #2 RST_N = 1'b0;
    model_reset();
    #1;
    checks++;
    if (swap_pending !== 1'b0 || wif.wr_ready !== 1'b1 || frame_cnt !== 8'd0 || red !== '0) begin
      errors++;
      $display("FAIL async_reset: got pend=%b rdy=%b cnt=%0d red=%h want 0/1/0/0",
               swap_pending, wif.wr_ready, frame_cnt, red);
    end
    @(negedge CLK);
    RST_N = 1'b1;
    tick = 1'b1; step(); tick = 1'b0;
    step(); step();
    checks++;
    if (frame_cnt !== 8'd0 || red !== '0 || green !== '0 || swap_pending !== 1'b0) begin
      errors++;
      $display("FAIL no_swap_after_reset: got cnt=%0d red=%h pend=%b want 0,0,0",
               frame_cnt, red, swap_pending);
    end
  endtask

  task automatic test_basic_frame();
    logic [R-1:0][C-1:0] er, eg;
    do_reset();
    write_row(4'd0, 16'hA5A5, 16'h0F0F);
    commit = 1'b1; step(); commit = 1'b0;
    tick = 1'b1; step(); tick = 1'b0;
    checks++;
    if (red !== '0 || wif.wr_ready !== 1'b0 || swap_pending !== 1'b0) begin
      errors++;
      $display("FAIL swap_cycle: got red=%h rdy=%b pend=%b want 0,0,0", red, wif.wr_ready, swap_pending);
    end
    step();
    er = '0; er[R-1] = 16'hA5A5;
    eg = '0; eg[R-1] = 16'h0F0F;
    checks++;
    if (red !== er || green !== eg) begin
      errors++;
      $display("FAIL basic_frame: got red=%h green=%h want red=%h green=%h", red, green, er, eg);
    end
    checks++;
    if (frame_cnt !== 8'd1 || wif.wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL basic_cnt: got cnt=%0d rdy=%b want 1,1", frame_cnt, wif.wr_ready);
    end
  endtask

  task automatic test_tear_free();
    commit = 1'b1; step(); commit = 1'b0;
    wif.wr_valid = 1'b1; wif.wr_row = 4'd2; wif.wr_red = 16'hFFFF; wif.wr_green = 16'hFFFF;
    #1;
    checks++;
    if (wif.wr_ready !== 1'b0) begin
      errors++;
      $display("FAIL stall_pending: got rdy=%b want 0", wif.wr_ready);
    end
    step();
    tick = 1'b1; step(); tick = 1'b0;
    step();
    checks++;
    if (wif.wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_swap: got %b want 1", wif.wr_ready);
    end
    step();
    wif.wr_valid = 1'b0;
    step(); step();
    checks++;
    if (red[R-1-2] !== 16'h0000 || red !== exp_red()) begin
      errors++;
      $display("FAIL front_untouched: got row=%h want 0000", red[R-1-2]);
    end
    commit_and_tick();
    checks++;
    if (red[R-1-2] !== 16'hFFFF || green[R-1-2] !== 16'hFFFF || red[R-1] !== 16'hA5A5) begin
      errors++;
      $display("FAIL stalled_write_shown: got r=%h g=%h r0=%h want ffff ffff a5a5",
               red[R-1-2], green[R-1-2], red[R-1]);
    end
  endtask

  task automatic test_clear_collision();
    logic [R-1:0][C-1:0] er;
    for (int i = 0; i < R; i++) write_row(4'(i), 16'hFFFF, 16'hFFFF);
    clear = 1'b1;
    write_row(4'd5, 16'h1234, 16'h0000);
    clear = 1'b0;
    commit_and_tick();
    er = '0; er[R-1-5] = 16'h1234;
    checks++;
    if (red !== er || green !== '0) begin
      errors++;
      $display("FAIL clear_collision: got red=%h green=%h want red=%h green=0", red, green, er);
    end
  endtask

  task automatic test_ignored_events();
    logic [7:0] fc;
    fc = frame_cnt;
    tick = 1'b1; step(); tick = 1'b0;
    step(); step();
    checks++;
    if (frame_cnt !== fc || frame_cnt !== m_cnt) begin
      errors++;
      $display("FAIL idle_tick: got cnt=%0d want %0d", frame_cnt, m_cnt);
    end
    wif.wr_valid = 1'b1; wif.wr_row = 4'd13; wif.wr_red = 16'hFFFF; wif.wr_green = 16'hFFFF;
    #1;
    checks++;
    if (wif.wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL oob_handshake: got rdy=%b want 1", wif.wr_ready);
    end
    step();
    wif.wr_valid = 1'b0;
    commit_and_tick();
    checks++;
    if (red[R-1-5] !== 16'h1234 || red !== exp_red() || green !== '0) begin
      errors++;
      $display("FAIL oob_discard: got red=%h want %h", red, exp_red());
    end
    do_reset();
    for (int i = 0; i < 256; i++) begin
      commit_and_tick();
      if (i == 254) begin
        checks++;
        if (frame_cnt !== 8'd255) begin
          errors++;
          $display("FAIL cnt_255: got %0d want 255", frame_cnt);
        end
      end
    end
    checks++;
    if (frame_cnt !== 8'd0) begin
      errors++;
      $display("FAIL cnt_wrap: got %0d want 0", frame_cnt);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 500; n++) begin
      wif.wr_valid = 1'($urandom_range(0, 1));
      wif.wr_row   = 4'($urandom_range(0, 15));
      wif.wr_red   = 16'($urandom);
      wif.wr_green = 16'($urandom);
      clear        = ($urandom_range(0, 7) == 0);
      commit       = ($urandom_range(0, 3) == 0);
      tick         = ($urandom_range(0, 3) == 0);
      blink_en     = 1'($urandom_range(0, 1));
      #1;
      checks++;
      if (wif.wr_ready !== !(m_pending || m_swap) || swap_pending !== m_pending) begin
        errors++;
        $display("FAIL rnd_ctrl n=%0d: got rdy=%b pend=%b want rdy=%b pend=%b",
                 n, wif.wr_ready, swap_pending, !(m_pending || m_swap), m_pending);
      end
      step();
      checks++;
      if (frame_cnt !== m_cnt || red !== exp_red() || green !== exp_green()) begin
        errors++;
        $display("FAIL rnd_out n=%0d: got cnt=%0d red=%h green=%h want cnt=%0d red=%h green=%h",
                 n, frame_cnt, red, green, m_cnt, exp_red(), exp_green());
      end
    end
    idle_inputs();
    blink_en = 1'b0;
  endtask

`ifdef LED_FRAME_BUFFER_BLINK_EN
  task automatic test_blink();
    logic [C-1:0] want[8];
    logic [C-1:0] pat;
    pat = 16'h0001;
    want[0] = pat; want[1] = pat; want[2] = '0; want[3] = '0;
    want[4] = '0;  want[5] = '0;  want[6] = pat;
    do_reset();
    blink_en = 1'b1;
    write_row(4'd0, 16'h0001, 16'h0000);
    commit = 1'b1; step(); commit = 1'b0;
    tick = 1'b1; step(); tick = 1'b0;
    step();
    checks++;
    if (red[R-1] !== want[0]) begin
      errors++;
      $display("FAIL blink_first: got %h want %h", red[R-1], want[0]);
    end
    for (int k = 1; k <= 6; k++) begin
      tick = (k % 2 == 1);
      step();
      tick = 1'b0;
      checks++;
      if (red[R-1] !== want[k] || red !== exp_red()) begin
        errors++;
        $display("FAIL blink_phase k=%0d: got %h want %h", k, red[R-1], want[k]);
      end
    end
    for (int n = 0; n < 40; n++) begin
      tick = 1'($urandom_range(0, 1));
      step();
      checks++;
      if (red !== exp_red() || green !== exp_green()) begin
        errors++;
        $display("FAIL blink_rnd n=%0d: got red=%h want %h", n, red, exp_red());
      end
    end
    blink_en = 1'b0;
    for (int n = 0; n < 30; n++) begin
      tick = 1'($urandom_range(0, 1));
      step();
      checks++;
      if (red[R-1] !== pat) begin
        errors++;
        $display("FAIL blink_off n=%0d: got %h want %h", n, red[R-1], pat);
      end
    end
    idle_inputs();
  endtask
`endif

  initial begin
    model_reset();
    idle_inputs();
    test_reset();
    test_basic_frame();
    test_tear_free();
    test_clear_collision();
    test_ignored_events();
    test_random();
`ifdef LED_FRAME_BUFFER_BLINK_EN
    test_blink();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
